// File: rtl/ss_write_data_if.sv
// Stream-in / RAM-write-out bus for the seven-segment RAM fill stage.
// Handshake: a word transfers on a rising clock edge where i_data_valid and
// o_ready are both high; i_data_last is only meaningful together with
// i_data_valid; o_we_ram qualifies o_addr_ram/o_data_ram for one cycle.
interface ss_write_data_if #(
   parameter int SIZE_ADDR = 6,
   parameter int SIZE_DATA = 8
);
   logic [SIZE_DATA-1:0] i_data_in;
   logic                 i_data_valid;
   logic                 i_data_last;
   logic                 o_ready;
   logic                 o_we_ram;
   logic [SIZE_ADDR-1:0] o_addr_ram;
   logic [SIZE_DATA-1:0] o_data_ram;

   // Producer side: drives the stream, observes ready and the RAM strobe.
   modport master (
      output i_data_in, i_data_valid, i_data_last,
      input  o_ready, o_we_ram, o_addr_ram, o_data_ram
   );

   // Fill stage side: consumes the stream, drives ready and the RAM port.
   modport slave (
      input  i_data_in, i_data_valid, i_data_last,
      output o_ready, o_we_ram, o_addr_ram, o_data_ram
   );
endinterface

// File: rtl/ss_write_data.sv
// Fill stage: writes a valid-qualified word stream into the display RAM from
// a programmable base address, tracks the written range and pulses done one
// cycle after the final write strobe so the read stage sees a filled RAM.
module ss_write_data #(
   parameter int SIZE_ADDR = 6,
   parameter int SIZE_DATA = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start_write_data,
   input  logic [SIZE_ADDR-1:0] i_base_addr,
   ss_write_data_if.slave       bus,
   output logic [SIZE_ADDR-1:0] o_si_ram,
   output logic [SIZE_ADDR-1:0] o_ei_ram,
   output logic [SIZE_ADDR:0]   o_count,
   output logic                 o_overflow,
   output logic                 o_done_write_data,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int unsigned          CAP      = 1 << SIZE_ADDR;
   localparam logic [SIZE_ADDR:0]   FULL_CNT = CAP[SIZE_ADDR:0];

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_start_d;

   logic                 r_ready;
   logic                 r_we;
   logic [SIZE_ADDR-1:0] r_addr;
   logic [SIZE_DATA-1:0] r_data;
   logic [SIZE_ADDR-1:0] r_ptr;
   logic [SIZE_ADDR-1:0] r_si;
   logic [SIZE_ADDR-1:0] r_ei;
   logic [SIZE_ADDR:0]   r_cnt;
   logic                 r_ovf;
   logic                 r_done;

   logic                 w_ready_nxt;
   logic                 w_we_nxt;
   logic [SIZE_ADDR-1:0] w_addr_nxt;
   logic [SIZE_DATA-1:0] w_data_nxt;
   logic [SIZE_ADDR-1:0] w_ptr_nxt;
   logic [SIZE_ADDR-1:0] w_si_nxt;
   logic [SIZE_ADDR-1:0] w_ei_nxt;
   logic [SIZE_ADDR:0]   w_cnt_nxt;
   logic                 w_ovf_nxt;
   logic                 w_done_nxt;

   logic                 w_start_edge;
   logic                 w_in_write;
   logic                 w_accept;
   logic                 w_end;
   logic [SIZE_ADDR:0]   w_cnt_inc;

   // A held-high start level produces a single edge; only IDLE listens to it.
   assign w_start_edge = i_start_write_data & ~r_start_d;
   assign w_in_write   = (r_state == ST_WRITE);
   // r_ready is already low when full, so a full-time word is never accepted.
   assign w_accept     = w_in_write & bus.i_data_valid & r_ready;
   // The session closes on a last word even if it is dropped while full.
   assign w_end        = w_in_write & bus.i_data_valid & bus.i_data_last;
   assign w_cnt_inc    = r_cnt + 1'b1;

   // Previous sample of the start level for rising-edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_start_d <= 1'b0;
      else          r_start_d <= i_start_write_data;
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state: IDLE -> WRITE on start edge, WRITE -> DONE on last, DONE lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_edge) w_state_nxt = ST_WRITE;
         ST_WRITE: if (w_end)        w_state_nxt = ST_DONE;
         ST_DONE:                    w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   // Output/datapath next values; everything holds unless the state says otherwise.
   always_comb begin
      w_ready_nxt = r_ready;
      w_we_nxt    = 1'b0;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_ptr_nxt   = r_ptr;
      w_si_nxt    = r_si;
      w_ei_nxt    = r_ei;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_ovf;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready_nxt = 1'b0;
            if (w_start_edge) begin
               w_ptr_nxt   = i_base_addr;
               w_si_nxt    = i_base_addr;
               w_ei_nxt    = i_base_addr;
               w_cnt_nxt   = '0;
               w_ovf_nxt   = 1'b0;
               w_ready_nxt = 1'b1;
            end
         end
         ST_WRITE: begin
            if (w_accept) begin
               w_we_nxt   = 1'b1;
               w_addr_nxt = r_ptr;
               w_data_nxt = bus.i_data_in;
               w_ei_nxt   = r_ptr;
               w_ptr_nxt  = r_ptr + 1'b1;
               w_cnt_nxt  = w_cnt_inc;
               if (w_cnt_inc == FULL_CNT) w_ready_nxt = 1'b0;
            end
            if (bus.i_data_valid && !r_ready) w_ovf_nxt = 1'b1;
            if (w_end) w_ready_nxt = 1'b0;
         end
         ST_DONE: begin
            w_ready_nxt = 1'b0;
            w_done_nxt  = 1'b1;
         end
         default: begin
            w_ready_nxt = 1'b0;
         end
      endcase
   end

   // Registered outputs: one stage between accept and RAM strobe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ptr   <= '0;
         r_si    <= '0;
         r_ei    <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_ptr   <= w_ptr_nxt;
         r_si    <= w_si_nxt;
         r_ei    <= w_ei_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.o_ready        = r_ready;
   assign bus.o_we_ram       = r_we;
   assign bus.o_addr_ram     = r_addr;
   assign bus.o_data_ram     = r_data;
   assign o_si_ram           = r_si;
   assign o_ei_ram           = r_ei;
   assign o_count            = r_cnt;
   assign o_overflow         = r_ovf;
   assign o_done_write_data  = r_done;
   assign o_dbg_state        = r_state;

endmodule
